status_reg: RTL and testbench

- 6502 processor-status (P) register; consumer end of the ALU flag interface.
- Captures the ALU's 4-bit flag vector {N,V,Z,C} under per-flag write masks.
- Executes the flag instructions (CLC/SEC/CLI/SEI/CLD/SED/CLV), plus BIT, PLP/RTI loads and PHP/BRK packing.
- Feeds the carry back to the ALU's carry_in, evaluates branch conditions, and produces the latency-correct IRQ mask for the interrupt controller.

---
 rtl/status_reg_if.sv | 38 +++
 rtl/status_reg.sv | 166 ++++++++++++++++
 tb/tb_status_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/status_reg_if.sv
// Flag/bus interface between the CPU datapath/sequencer and the status_reg block.
// The master drives ALU flags, memory data and control strobes; the slave returns P state.
interface status_reg_if;
    logic [3:0] alu_flags;
    logic [3:0] flag_we;
    logic       bit_we;
    logic [7:0] mem_data;
    logic       plp_we;
    logic [2:0] flag_op;
    logic       irq_entry;
    logic       instr_boundary;
    logic       push_brk;
    logic [2:0] cond_sel;
    logic [7:0] p_out;
    logic       carry_out;
    logic       branch_taken;
    logic       irq_mask;
    logic       flag_n;
    logic       flag_v;
    logic       flag_d;
    logic       flag_i;
    logic       flag_z;
    logic       flag_c;

    modport master (
        output alu_flags, flag_we, bit_we, mem_data, plp_we, flag_op,
               irq_entry, instr_boundary, push_brk, cond_sel,
        input  p_out, carry_out, branch_taken, irq_mask,
               flag_n, flag_v, flag_d, flag_i, flag_z, flag_c
    );

    modport slave (
        input  alu_flags, flag_we, bit_we, mem_data, plp_we, flag_op,
               irq_entry, instr_boundary, push_brk, cond_sel,
        output p_out, carry_out, branch_taken, irq_mask,
               flag_n, flag_v, flag_d, flag_i, flag_z, flag_c
    );
endinterface

// File: rtl/status_reg.sv
// 6502 processor-status register: flag capture, flag instructions, PLP/PHP packing,
// branch evaluation and delayed IRQ mask. Define STATUS_DECIMAL_EN to store the D flag.
module status_reg #(
    parameter logic RESET_I  = 1'b1,
    parameter logic BIT5_VAL = 1'b1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    status_reg_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLC  = 3'd1,
        OP_SEC  = 3'd2,
        OP_CLI  = 3'd3,
        OP_SEI  = 3'd4,
        OP_CLD  = 3'd5,
        OP_SED  = 3'd6,
        OP_CLV  = 3'd7
    } flag_op_e;

    typedef enum logic [2:0] {
        BR_BPL = 3'd0,
        BR_BMI = 3'd1,
        BR_BVC = 3'd2,
        BR_BVS = 3'd3,
        BR_BCC = 3'd4,
        BR_BCS = 3'd5,
        BR_BNE = 3'd6,
        BR_BEQ = 3'd7
    } cond_e;

    logic r_n, r_v, r_i, r_z, r_c, r_irq_mask;
    logic w_n, w_v, w_i, w_z, w_c, w_irq_mask;
    logic w_d_flag;
    logic w_branch;
    flag_op_e w_op;
    cond_e    w_cond;

    assign w_op   = flag_op_e'(bus.flag_op);
    assign w_cond = cond_e'(bus.cond_sel);

`ifdef STATUS_DECIMAL_EN
    logic r_d, w_d;

    always_comb begin
        w_d = r_d;
        if (bus.plp_we)
            w_d = bus.mem_data[3];
        else if (w_op == OP_CLD)
            w_d = 1'b0;
        else if (w_op == OP_SED)
            w_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_d <= 1'b0;
        else
            r_d <= w_d;
    end

    assign w_d_flag = r_d;
`else
    assign w_d_flag = 1'b0;
`endif

    // PLP wins outright; otherwise each flag resolves flag_op > bit_we > flag_we > hold.
    always_comb begin
        w_n = r_n;
        w_v = r_v;
        w_i = r_i;
        w_z = r_z;
        w_c = r_c;
        if (bus.plp_we) begin
            w_n = bus.mem_data[7];
            w_v = bus.mem_data[6];
            w_i = bus.mem_data[2];
            w_z = bus.mem_data[1];
            w_c = bus.mem_data[0];
        end else begin
            if (bus.bit_we)
                w_n = bus.mem_data[7];
            else if (bus.flag_we[3])
                w_n = bus.alu_flags[3];

            if (w_op == OP_CLV)
                w_v = 1'b0;
            else if (bus.bit_we)
                w_v = bus.mem_data[6];
            else if (bus.flag_we[2])
                w_v = bus.alu_flags[2];

            if (bus.bit_we || bus.flag_we[1])
                w_z = bus.alu_flags[1];

            if (w_op == OP_CLC)
                w_c = 1'b0;
            else if (w_op == OP_SEC)
                w_c = 1'b1;
            else if (bus.flag_we[0])
                w_c = bus.alu_flags[0];

            if (w_op == OP_CLI)
                w_i = 1'b0;
            else if (w_op == OP_SEI)
                w_i = 1'b1;
        end
        if (bus.irq_entry)
            w_i = 1'b1;
    end

    // The mask samples the pre-edge I, giving CLI/SEI/PLP their one-instruction delay.
    always_comb begin
        w_irq_mask = r_irq_mask;
        if (bus.irq_entry)
            w_irq_mask = 1'b1;
        else if (bus.instr_boundary)
            w_irq_mask = r_i;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_n        <= 1'b0;
            r_v        <= 1'b0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_i        <= RESET_I;
            r_irq_mask <= RESET_I;
        end else begin
            r_n        <= w_n;
            r_v        <= w_v;
            r_z        <= w_z;
            r_c        <= w_c;
            r_i        <= w_i;
            r_irq_mask <= w_irq_mask;
        end
    end

    always_comb begin
        w_branch = 1'b0;
        unique case (w_cond)
            BR_BPL: w_branch = ~r_n;
            BR_BMI: w_branch = r_n;
            BR_BVC: w_branch = ~r_v;
            BR_BVS: w_branch = r_v;
            BR_BCC: w_branch = ~r_c;
            BR_BCS: w_branch = r_c;
            BR_BNE: w_branch = ~r_z;
            BR_BEQ: w_branch = r_z;
        endcase
    end

    assign bus.p_out        = {r_n, r_v, BIT5_VAL, bus.push_brk, w_d_flag, r_i, r_z, r_c};
    assign bus.carry_out    = r_c;
    assign bus.branch_taken = w_branch;
    assign bus.irq_mask     = r_irq_mask;
    assign bus.flag_n       = r_n;
    assign bus.flag_v       = r_v;
    assign bus.flag_d       = w_d_flag;
    assign bus.flag_i       = r_i;
    assign bus.flag_z       = r_z;
    assign bus.flag_c       = r_c;

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: byte-level P model checked every cycle plus
// directed literal checks. Honours STATUS_DECIMAL_EN for the expected D behaviour.
module tb_status_reg;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    status_reg_if bus();

    status_reg #(.RESET_I(1'b1), .BIT5_VAL(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

`ifdef STATUS_DECIMAL_EN
    localparam logic [7:0] P_MASK = 8'hCF;
    localparam logic       D_ON   = 1'b1;
`else
    localparam logic [7:0] P_MASK = 8'hC7;
    localparam logic       D_ON   = 1'b0;
`endif

    // flag_op -> (bit position in P, value written); entry 0 is unused
    int   op_bit[8] = '{0, 0, 0, 2, 2, 3, 3, 6};
    logic op_val[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // branch pair (cond_sel/2) -> P bit tested; odd cond_sel takes on set
    int   br_bit[4] = '{7, 6, 0, 1};

    logic [7:0] m_p;
    logic       m_irq;
    logic       m_ok = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: P kept as a byte, updates layered lowest priority first
    always @(posedge clk) begin
        logic [7:0] nx, alu_b, we_b;
        if (!rst_n) begin
            m_p   = 8'h04;
            m_irq = 1'b1;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            nx = m_p;
            if (bus.plp_we) begin
                nx = bus.mem_data & P_MASK;
            end else begin
                alu_b = {bus.alu_flags[3:2], 4'b0000, bus.alu_flags[1:0]};
                we_b  = {bus.flag_we[3:2], 4'b0000, bus.flag_we[1:0]};
                nx = (nx & ~we_b) | (alu_b & we_b);
                if (bus.bit_we)
                    nx = (nx & 8'h3D) | (bus.mem_data & 8'hC0) | {6'b0, bus.alu_flags[1], 1'b0};
                if (bus.flag_op != 3'd0)
                    nx[op_bit[bus.flag_op]] = op_val[bus.flag_op];
                nx = nx & P_MASK;
            end
            if (bus.irq_entry)
                nx[2] = 1'b1;
            if (bus.irq_entry)
                m_irq = 1'b1;
            else if (bus.instr_boundary)
                m_irq = m_p[2];
            m_p = nx;
        end
    end

    // Compare process: mid-cycle, when inputs and outputs are stable
    always @(negedge clk) begin
        logic exp_br;
        if (m_ok) begin
            exp_br = bus.cond_sel[0] ? m_p[br_bit[bus.cond_sel[2:1]]] : ~m_p[br_bit[bus.cond_sel[2:1]]];
            chk("p_out", bus.p_out, m_p | 8'h20 | {3'b000, bus.push_brk, 4'b0000});
            chk("carry_out", {7'b0, bus.carry_out}, {7'b0, m_p[0]});
            chk("branch_taken", {7'b0, bus.branch_taken}, {7'b0, exp_br});
            chk("irq_mask", {7'b0, bus.irq_mask}, {7'b0, m_irq});
            chk("flags", {2'b00, bus.flag_n, bus.flag_v, bus.flag_d, bus.flag_i, bus.flag_z, bus.flag_c},
                {2'b00, m_p[7], m_p[6], m_p[3], m_p[2], m_p[1], m_p[0]});
        end
    end

    task automatic idle();
        bus.alu_flags = '0; bus.flag_we = '0; bus.bit_we = 1'b0; bus.mem_data = '0;
        bus.plp_we = 1'b0; bus.flag_op = '0; bus.irq_entry = 1'b0;
        bus.instr_boundary = 1'b0; bus.push_brk = 1'b0; bus.cond_sel = '0;
    endtask

    // Advance one edge; inputs change 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        chk("reset p_out", bus.p_out, 8'h24);
        chk("reset irq_mask", {7'b0, bus.irq_mask}, 8'h01);
        chk("reset carry", {7'b0, bus.carry_out}, 8'h00);
        bus.push_brk = 1'b1;
        #1 chk("reset p_out brk", bus.p_out, 8'h34);
        bus.push_brk = 1'b0;

        rst_n = 1'b1;
        bus.alu_flags = 4'b1011; bus.flag_we = 4'b1001;
        tick();
        idle();
        chk("alu NVZC", {4'b0, bus.flag_n, bus.flag_v, bus.flag_z, bus.flag_c}, 8'h09);
        chk("alu carry_out", {7'b0, bus.carry_out}, 8'h01);

        bus.mem_data = 8'hFF; bus.plp_we = 1'b1;
        tick();
        idle();
        chk("plp p_out", bus.p_out, D_ON ? 8'hEF : 8'hE7);

        bus.flag_op = 3'd3;
        tick();
        idle();
        chk("cli I", {7'b0, bus.flag_i}, 8'h00);
        chk("cli mask held", {7'b0, bus.irq_mask}, 8'h01);
        bus.instr_boundary = 1'b1;
        tick();
        idle();
        chk("cli mask boundary", {7'b0, bus.irq_mask}, 8'h00);

        bus.flag_op = 3'd3; bus.irq_entry = 1'b1;
        tick();
        idle();
        chk("irq_entry I", {7'b0, bus.flag_i}, 8'h01);
        chk("irq_entry mask", {7'b0, bus.irq_mask}, 8'h01);

        bus.flag_op = 3'd2; bus.flag_we = 4'b0001; bus.alu_flags = 4'b0000;
        tick();
        idle();
        chk("sec over alu", {7'b0, bus.flag_c}, 8'h01);
        bus.bit_we = 1'b1; bus.mem_data = 8'hC0; bus.alu_flags = 4'b0010; bus.flag_we = 4'b1000;
        tick();
        idle();
        chk("bit NVZ", {5'b0, bus.flag_n, bus.flag_v, bus.flag_z}, 8'h07);

        bus.flag_op = 3'd1;
        tick();
        idle();
        bus.cond_sel = 3'd7;
        #1 chk("beq", {7'b0, bus.branch_taken}, 8'h01);
        bus.cond_sel = 3'd6;
        #1 chk("bne", {7'b0, bus.branch_taken}, 8'h00);
        bus.cond_sel = 3'd4;
        #1 chk("bcc", {7'b0, bus.branch_taken}, 8'h01);
        bus.cond_sel = 3'd5; bus.flag_op = 3'd2;
        #1 chk("bcs pre-edge", {7'b0, bus.branch_taken}, 8'h00);
        tick();
        idle();

        bus.flag_op = 3'd3;
        tick();
        bus.flag_op = 3'd4; bus.instr_boundary = 1'b1;
        tick();
        idle();
        chk("sei boundary mask", {7'b0, bus.irq_mask}, 8'h00);
        chk("sei I", {7'b0, bus.flag_i}, 8'h01);

        bus.flag_op = 3'd6;
        tick();
        idle();
        chk("sed D", {7'b0, bus.flag_d}, {7'b0, D_ON});

        rst_n = 1'b0; bus.plp_we = 1'b1; bus.mem_data = 8'hFF; bus.flag_op = 3'd2;
        tick();
        idle();
        rst_n = 1'b1;
        chk("mid reset p_out", bus.p_out, 8'h24);

        for (int k = 0; k < 200; k++) begin
            bus.alu_flags      = 4'($urandom);
            bus.flag_we        = 4'($urandom);
            bus.bit_we         = ($urandom_range(0, 5) == 0);
            bus.mem_data       = 8'($urandom);
            bus.plp_we         = ($urandom_range(0, 7) == 0);
            bus.flag_op        = 3'($urandom);
            bus.irq_entry      = ($urandom_range(0, 9) == 0);
            bus.instr_boundary = ($urandom_range(0, 2) == 0);
            bus.push_brk       = 1'($urandom);
            bus.cond_sel       = 3'($urandom);
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
